enc4to2_rr: RTL and testbench

- Sequential 4-to-2 encoder: the encode-side counterpart of the team's 2-to-4 decoder.
- Captures four request lines i0..i3 into a sticky pending register and emits one 2-bit index (y1,y0) per valid/ack handshake.
- Selection is round-robin by default, or fixed priority (i0 highest) when configured.
- Sits ahead of a deco2to4 instance, so a downstream consumer can re-expand the index to one-hot.

---
 rtl/enc4to2_rr.sv | 130 +++++++++++++
 tb/tb_enc4to2_rr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc4to2_rr.sv
// enc4to2_rr: sequential 4-to-2 encoder with sticky pending requests,
// round-robin or fixed-priority selection, and a valid/ack handshake.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   i0..i3 - request lines, level-sampled into the pending register
//   ack    - consumer accepts the presented index
//   y1,y0  - encoded index {y1,y0}
//   valid  - {y1,y0} holds a granted index
//   multi  - more than one request was pending at selection time
//   pend   - pending request bits {i3,i2,i1,i0}
module enc4to2_rr #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       ack,
  output logic       y0,
  output logic       y1,
  output logic       valid,
  output logic       multi,
  output logic [3:0] pend
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;
  logic [1:0] ptr_q, ptr_d;

  logic [3:0] req;
  logic       accept;
  logic [3:0] clr_mask;
  logic [1:0] sel_idx;
  logic       sel_hit;
  logic       sel_multi;

  assign req    = {i3, i2, i1, i0};
  assign accept = valid_q & ack;

  // A fresh request in the retiring cycle re-sets the bit.
  assign clr_mask = accept ? (4'b0001 << y_q) : 4'b0000;
  assign pend_d   = (pend_q & ~clr_mask) | req;

  assign sel_multi = $countones(pend_q) > 1;

  // Scan from the base index upward, wrapping mod 4.
  always_comb begin
    logic [1:0] base;
    logic [1:0] idx;
    sel_idx = 2'd0;
    sel_hit = 1'b0;
    idx     = 2'd0;
    base    = FIXED_PRIO ? 2'd0 : ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!sel_hit && pend_q[idx]) begin
        sel_hit = 1'b1;
        sel_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_hit) begin
          y_d     = sel_idx;
          valid_d = 1'b1;
          multi_d = sel_multi;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (!FIXED_PRIO) begin
            ptr_d = y_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      y_q     <= 2'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y0    = y_q[0];
  assign y1    = y_q[1];
  assign valid = valid_q;
  assign multi = multi_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_enc4to2_rr.sv
// tb_enc4to2_rr: drives a round-robin and a fixed-priority enc4to2_rr
// with shared stimulus and compares both against a behavioural model.
module tb_enc4to2_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;

  logic       rr_y0, rr_y1, rr_valid, rr_multi;
  logic [3:0] rr_pend;
  logic       fp_y0, fp_y1, fp_valid, fp_multi;
  logic [3:0] fp_pend;
  logic [1:0] rr_y, fp_y;

  assign rr_y = {rr_y1, rr_y0};
  assign fp_y = {fp_y1, fp_y0};

  int passed = 0;
  int total  = 0;

  // Model, index 0 = round-robin DUT, index 1 = fixed-priority DUT.
  int m_pend[2];
  int m_y[2];
  int m_ptr[2];
  bit m_valid[2];
  bit m_multi[2];

  always #5 clk = ~clk;

  enc4to2_rr #(.FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
    .ack(ack),
    .y0(rr_y0), .y1(rr_y1),
    .valid(rr_valid), .multi(rr_multi), .pend(rr_pend)
  );

  enc4to2_rr #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
    .ack(ack),
    .y0(fp_y0), .y1(fp_y1),
    .valid(fp_valid), .multi(fp_multi), .pend(fp_pend)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 0;
      m_y[d]     = 0;
      m_ptr[d]   = 0;
      m_valid[d] = 1'b0;
      m_multi[d] = 1'b0;
    end
  endtask

  // One clock of the reference: grant from the old pending set,
  // retire on handshake, then merge the new requests.
  task automatic model_update();
    int r;
    r = int'(req);
    for (int d = 0; d < 2; d++) begin
      int old;
      int clr;
      old = m_pend[d];
      clr = 0;
      if (m_valid[d]) begin
        if (ack) begin
          clr = 1 << m_y[d];
          m_valid[d] = 1'b0;
          if (d == 0) m_ptr[d] = (m_y[d] + 1) % 4;
        end
      end else if (old != 0) begin
        int start;
        start = (d == 1) ? 0 : m_ptr[d];
        for (int k = 3; k >= 0; k--) begin
          int n;
          n = (start + k) % 4;
          if (old[n]) m_y[d] = n;
        end
        m_valid[d] = 1'b1;
        m_multi[d] = $countones(old[3:0]) > 1;
      end
      m_pend[d] = (old & ~clr) | r;
    end
  endtask

  task automatic check_all();
    chk("rr_valid", 8'(rr_valid), 8'(m_valid[0]));
    chk("rr_y",     8'(rr_y),     8'(m_y[0]));
    chk("rr_multi", 8'(rr_multi), 8'(m_multi[0]));
    chk("rr_pend",  8'(rr_pend),  8'(m_pend[0]));
    chk("fp_valid", 8'(fp_valid), 8'(m_valid[1]));
    chk("fp_y",     8'(fp_y),     8'(m_y[1]));
    chk("fp_multi", 8'(fp_multi), 8'(m_multi[1]));
    chk("fp_pend",  8'(fp_pend),  8'(m_pend[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rr_valid", 8'(rr_valid), 8'h00);
    chk("rst_rr_pend",  8'(rr_pend),  8'h00);
    chk("rst_rr_y",     8'(rr_y),     8'h00);
    chk("rst_fp_valid", 8'(fp_valid), 8'h00);
    chk("rst_fp_pend",  8'(fp_pend),  8'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};

    // Reset with every request high.
    req = 4'hF;
    #2;
    do_reset();
    step();
    chk("rel_pend", 8'(rr_pend), 8'h0F);
    chk("rel_valid_early", 8'(rr_valid), 8'h00);
    step();
    chk("rel_valid", 8'(rr_valid), 8'h01);
    chk("rel_y", 8'(rr_y), 8'h00);
    chk("rel_multi", 8'(rr_multi), 8'h01);

    // Fairness with all lines held high and immediate acks.
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 8'(rr_y), 8'(exp_rr[g]));
      chk("fp_grant", 8'(fp_y), 8'h00);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("rr_gap", 8'(rr_valid), 8'h00);
      step();
      chk("rr_regrant", 8'(rr_valid), 8'h01);
    end

    // Fixed priority: drop i0 before its ack, i1 then wins repeatedly.
    req = 4'hE;
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("fp_drop0", 8'(fp_y), 8'h01);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("fp_drop1", 8'(fp_y), 8'h01);

    // Reset while a grant is being presented.
    req = 4'h0;
    do_reset();

    // Set/clear collision on index 01.
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    chk("col_y", 8'(rr_y), 8'h01);
    chk("col_multi", 8'(rr_multi), 8'h00);
    ack = 1'b1;
    req = 4'b0010;
    step();
    chk("col_pend", 8'(rr_pend), 8'h02);
    ack = 1'b0;
    req = 4'b0000;
    step();
    chk("col_regrant_v", 8'(rr_valid), 8'h01);
    chk("col_regrant_y", 8'(rr_y), 8'h01);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Ack while idle is ignored.
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    chk("ign_pend", 8'(rr_pend), 8'h00);
    chk("ign_valid", 8'(rr_valid), 8'h00);

    // Single request, consumer waits three cycles.
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    chk("sgl_valid", 8'(rr_valid), 8'h01);
    chk("sgl_multi", 8'(rr_multi), 8'h00);
    for (int w = 0; w < 3; w++) begin
      step();
      chk("sgl_hold", 8'(rr_y), 8'h02);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sgl_gap", 8'(rr_valid), 8'h00);
    chk("sgl_pend", 8'(rr_pend), 8'h00);
    step();
    chk("sgl_idle", 8'(rr_valid), 8'h00);

    // Wrap: pointer sits at 3, pending 1001.
    req = 4'b1001;
    step();
    req = 4'b0000;
    step();
    chk("wrap_y3", 8'(rr_y), 8'h03);
    chk("wrap_multi", 8'(rr_multi), 8'h01);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("wrap_y0", 8'(rr_y), 8'h00);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 4'b0011;
    step();
    req = 4'b0000;
    step();
    chk("wrap_ptr1", 8'(rr_y), 8'h01);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        for (int b = 0; b < 4; b++) begin
          req[b] = ($urandom_range(0, 3) == 0);
        end
        ack = 1'($urandom_range(0, 1));
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
